// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EX->MEM handshake, data-SRAM load
// response, MEM->WB handshake and the forwarding/stall bus back to ID.
interface mem_stage_if #(
  parameter int ES_TO_MS_WD = 76,
  parameter int MS_TO_WS_WD = 70
);
  logic                   es_to_ms_valid;
  logic [ES_TO_MS_WD-1:0] es_to_ms_bus;
  logic                   ms_allow_in;
  logic                   data_sram_data_ok;
  logic [31:0]            data_sram_rdata;
  logic                   ms_to_ws_valid;
  logic [MS_TO_WS_WD-1:0] ms_to_ws_bus;
  logic                   ws_allow_in;
  logic                   ms_fwd_valid;
  logic [4:0]             ms_fwd_dest;
  logic [31:0]            ms_fwd_result;
  logic                   ms_fwd_pending;

  modport master (
    output es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, ws_allow_in,
    input  ms_allow_in, ms_to_ws_valid, ms_to_ws_bus,
           ms_fwd_valid, ms_fwd_dest, ms_fwd_result, ms_fwd_pending
  );

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, data_sram_data_ok, data_sram_rdata, ws_allow_in,
    output ms_allow_in, ms_to_ws_valid, ms_to_ws_bus,
           ms_fwd_valid, ms_fwd_dest, ms_fwd_result, ms_fwd_pending
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for and aligns load data,
// hands results to WB and drives the forwarding/stall bus to ID.
module mem_stage #(
  parameter int ES_TO_MS_WD = 76,
  parameter int MS_TO_WS_WD = 70
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave ms_if
);
  logic                   ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_WD-1:0] bus_q, bus_d;
  logic                   buf_vld_q, buf_vld_d;
  logic [31:0]            buf_data_q, buf_data_d;

  logic        mem_ld;
  logic [2:0]  ld_type;
  logic [1:0]  addr_lo;
  logic        rf_we;
  logic [4:0]  dest;
  logic [31:0] pc;
  logic [31:0] alu_result;

  logic        ms_ready_go;
  logic        ms_allow_in;
  logic        ms_to_ws_valid;
  logic        wb_transfer;
  logic        buf_capture;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        fwd_valid;
  logic [MS_TO_WS_WD-1:0] ws_bus;

  assign {mem_ld, ld_type, addr_lo, rf_we, dest, pc, alu_result} = bus_q;

  assign ms_ready_go    = !mem_ld || ms_if.data_sram_data_ok || buf_vld_q;
  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ms_allow_in    = !ms_valid_q || (ms_ready_go && ms_if.ws_allow_in);
  assign wb_transfer    = ms_to_ws_valid && ms_if.ws_allow_in;

  // Park a response only when WB stalls; otherwise rdata flows straight through.
  assign buf_capture = ms_if.data_sram_data_ok && ms_valid_q && mem_ld &&
                       !buf_vld_q && !ms_if.ws_allow_in;

  assign load_word = buf_vld_q ? buf_data_q : ms_if.data_sram_rdata;
  assign load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_byte = load_word[7:0];
    case (addr_lo)
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      2'd3:    load_byte = load_word[31:24];
      default: load_byte = load_word[7:0];
    endcase
  end

  always_comb begin
    load_result = load_word;
    case (ld_type)
      3'b000:  load_result = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_result = {{16{load_half[15]}}, load_half};
      3'b100:  load_result = {24'd0, load_byte};
      3'b101:  load_result = {16'd0, load_half};
      default: load_result = load_word;
    endcase
  end

  assign final_result = mem_ld ? load_result : alu_result;

  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    if (rst) begin
      ms_valid_d = 1'b0;
      bus_d      = '0;
      buf_vld_d  = 1'b0;
      buf_data_d = 32'd0;
    end else begin
      if (ms_allow_in) begin
        ms_valid_d = ms_if.es_to_ms_valid;
      end
      if (ms_if.es_to_ms_valid && ms_allow_in) begin
        bus_d = ms_if.es_to_ms_bus;
      end
      if (wb_transfer) begin
        buf_vld_d = 1'b0;
      end else if (buf_capture) begin
        buf_vld_d  = 1'b1;
        buf_data_d = ms_if.data_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    ms_valid_q <= ms_valid_d;
    bus_q      <= bus_d;
    buf_vld_q  <= buf_vld_d;
    buf_data_q <= buf_data_d;
  end

  assign ws_bus    = {rf_we, dest, pc, final_result};
  assign fwd_valid = ms_valid_q && rf_we && (dest != 5'd0);

  assign ms_if.ms_allow_in    = ms_allow_in;
  assign ms_if.ms_to_ws_valid = ms_to_ws_valid;
  assign ms_if.ms_to_ws_bus   = ws_bus;
  assign ms_if.ms_fwd_valid   = fwd_valid;
  assign ms_if.ms_fwd_dest    = dest;
  assign ms_if.ms_fwd_result  = final_result;
  // ID may only consume the forwarded value once the load word is available.
  assign ms_if.ms_fwd_pending = fwd_valid && mem_ld && !ms_if.data_sram_data_ok && !buf_vld_q;
endmodule
